// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared definitions for the multi-channel clock divider.
//   RATIO_W_DEF  default width of one ratio field
//   half_hi()    number of high cycles in one period, ceil(ratio/2)
//   is_bypass()  ratios 0 and 1 pass the reference clock straight through
package clk_div_pkg;

  localparam int RATIO_W_DEF = 5;

  function automatic int unsigned half_hi(input int unsigned ratio);
    return (ratio + 1) / 2;
  endfunction

  function automatic logic is_bypass(input int unsigned ratio);
    return ratio < 2;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one programmable integer divider channel.
//   ref_clk    reference clock
//   rst        synchronous active-high reset
//   en         channel enable
//   ratio      requested ratio, captured into the shadow register on load
//   load       1-cycle strobe, captures ratio as pending
//   sync       1-cycle strobe, restarts the period when enabled
//   div_clk    divided clock (registered except in bypass)
//   ratio_ack  1-cycle pulse when a pending ratio becomes active
//   tick       period-start pulse, only built when CLK_DIV_TICK_EN is defined
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int RATIO_W   = RATIO_W_DEF,
  parameter int RST_RATIO = 2
) (
  input  logic               ref_clk,
  input  logic               rst,
  input  logic               en,
  input  logic [RATIO_W-1:0] ratio,
  input  logic               load,
  input  logic               sync,
  output logic               div_clk,
  output logic               ratio_ack,
  output logic               tick
);

  localparam logic [RATIO_W-1:0] ONE      = RATIO_W'(1);
  localparam logic [RATIO_W-1:0] RST_ACT  = RATIO_W'(RST_RATIO);
  localparam logic [RATIO_W-1:0] RST_PARK = (RST_RATIO < 2) ? '0 : RATIO_W'(RST_RATIO - 1);

  logic [RATIO_W-1:0] r_act;
  logic [RATIO_W-1:0] r_pend;
  logic [RATIO_W-1:0] cnt;
  logic               pend;
  logic               div_q;
  logic               ack_q;

  logic               act_byp;
  logic               new_byp;
  logic               boundary;
  logic               apply;
  logic [RATIO_W-1:0] ratio_new;
  logic [RATIO_W-1:0] cnt_next;
  logic [RATIO_W-1:0] park_new;
  logic               div_next;

  // A boundary is any edge where a pending ratio may safely take over:
  // a natural wrap, every bypass edge, a disabled edge, or a sync restart.
  // The high/low decision always uses the ratio that is active after this edge.
  always_comb begin
    act_byp   = is_bypass(32'(r_act));
    boundary  = act_byp || (cnt == r_act - ONE) || !en || sync;
    apply     = boundary && pend;
    ratio_new = apply ? r_pend : r_act;
    new_byp   = is_bypass(32'(ratio_new));
    cnt_next  = boundary ? '0 : cnt + ONE;
    park_new  = new_byp ? '0 : ratio_new - ONE;
    div_next  = en && !new_byp && (32'(cnt_next) < half_hi(32'(ratio_new)));
  end

  // Disabled channels park the counter at the last count so the first
  // enabled edge wraps and raises the output immediately.
  // A load on an apply edge keeps the new value pending.
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      r_act  <= RST_ACT;
      r_pend <= '0;
      pend   <= 1'b0;
      cnt    <= RST_PARK;
      div_q  <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      r_act <= ratio_new;
      cnt   <= en ? cnt_next : park_new;
      div_q <= div_next;
      ack_q <= apply;
      if (load) begin
        r_pend <= ratio;
        pend   <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

  // Bypass is the single combinational path from the reference clock.
  assign div_clk   = act_byp ? (ref_clk & en & ~rst) : div_q;
  assign ratio_ack = ack_q;

`ifdef CLK_DIV_TICK_EN
  logic tick_q;

  // Fires with the div_q rise; in bypass every enabled edge starts a period.
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= en && (cnt_next == '0);
    end
  end

  assign tick = tick_q;
`else
  assign tick = 1'b0;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: N_CH independent programmable clock dividers on one reference clock.
//   i_ref_clk    reference clock
//   i_rst        synchronous active-high reset
//   i_clk_en     per-channel enable
//   i_div_ratio  requested ratios, channel k in bits [k*RATIO_W +: RATIO_W]
//   i_ratio_load 1-cycle strobe, captures all ratio fields as pending
//   i_sync       1-cycle strobe, restarts every enabled channel
//   o_div_clk    divided clocks
//   o_ratio_ack  per-channel pulse when a pending ratio becomes active
//   o_tick       period-start pulses, tied low unless CLK_DIV_TICK_EN is defined
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int RATIO_W   = RATIO_W_DEF,
  parameter int RST_RATIO = 2
) (
  input  logic                    i_ref_clk,
  input  logic                    i_rst,
  input  logic [N_CH-1:0]         i_clk_en,
  input  logic [N_CH*RATIO_W-1:0] i_div_ratio,
  input  logic                    i_ratio_load,
  input  logic                    i_sync,
  output logic [N_CH-1:0]         o_div_clk,
  output logic [N_CH-1:0]         o_ratio_ack,
  output logic [N_CH-1:0]         o_tick
);

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    clk_div_chan #(
      .RATIO_W   (RATIO_W),
      .RST_RATIO (RST_RATIO)
    ) u_chan (
      .ref_clk   (i_ref_clk),
      .rst       (i_rst),
      .en        (i_clk_en[k]),
      .ratio     (i_div_ratio[k*RATIO_W +: RATIO_W]),
      .load      (i_ratio_load),
      .sync      (i_sync),
      .div_clk   (o_div_clk[k]),
      .ratio_ack (o_ratio_ack[k]),
      .tick      (o_tick[k])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: scoreboard bench for clk_div_multi.
// The reference model tracks, per channel, the cycle on which the current
// period started and derives the output level from elapsed time.
module tb_clk_div_multi;

  localparam int N_CH      = 4;
  localparam int RW        = 5;
  localparam int RST_RATIO = 2;

  typedef struct packed {
    logic [N_CH-1:0] div;
    logic [N_CH-1:0] ack;
    logic [N_CH-1:0] tick;
  } exp_t;

  logic                 ref_clk = 1'b0;
  logic                 rst;
  logic [N_CH-1:0]      en;
  logic [N_CH*RW-1:0]   ratios;
  logic                 load;
  logic                 sync;
  logic [N_CH-1:0]      div_clk;
  logic [N_CH-1:0]      ratio_ack;
  logic [N_CH-1:0]      tick;

  exp_t   sb[$];
  int     checks  = 0;
  int     errors  = 0;
  longint cyc     = 0;
  longint mon_cyc = 0;

  int unsigned m_act[N_CH];
  int unsigned m_pendv[N_CH];
  bit          m_pend[N_CH];
  bit          m_started[N_CH];
  longint      m_t0[N_CH];

  logic [N_CH-1:0]    cur_en;
  logic [N_CH*RW-1:0] cur_ratio;

  clk_div_multi #(
    .N_CH      (N_CH),
    .RATIO_W   (RW),
    .RST_RATIO (RST_RATIO)
  ) dut (
    .i_ref_clk    (ref_clk),
    .i_rst        (rst),
    .i_clk_en     (en),
    .i_div_ratio  (ratios),
    .i_ratio_load (load),
    .i_sync       (sync),
    .o_div_clk    (div_clk),
    .o_ratio_ack  (ratio_ack),
    .o_tick       (tick)
  );

  always #5 ref_clk = ~ref_clk;

  function automatic logic [N_CH*RW-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
    logic [N_CH*RW-1:0] v;
    v = '0;
    v[0*RW +: RW] = RW'(c0);
    v[1*RW +: RW] = RW'(c1);
    v[2*RW +: RW] = RW'(c2);
    v[3*RW +: RW] = RW'(c3);
    return v;
  endfunction

  // Reference model: advance one reference edge using the inputs now applied.
  task automatic modelStep(output exp_t e);
    bit apply_now;
    e = '0;
    cyc++;
    for (int k = 0; k < N_CH; k++) begin
      if (rst) begin
        m_act[k]     = RST_RATIO;
        m_pend[k]    = 1'b0;
        m_started[k] = 1'b0;
      end else begin
        apply_now = 1'b0;
        if (!en[k]) begin
          apply_now    = m_pend[k];
          m_started[k] = 1'b0;
        end else if (m_act[k] < 2 || !m_started[k] || sync || (cyc - m_t0[k]) >= longint'(m_act[k])) begin
          apply_now    = m_pend[k];
          m_t0[k]      = cyc;
          m_started[k] = 1'b1;
        end
        if (apply_now) begin
          m_act[k]  = m_pendv[k];
          m_pend[k] = 1'b0;
          e.ack[k]  = 1'b1;
        end
        if (load) begin
          m_pendv[k] = int'(ratios[k*RW +: RW]);
          m_pend[k]  = 1'b1;
        end
        if (en[k]) begin
          if (m_act[k] < 2) e.div[k] = 1'b1;
          else              e.div[k] = (cyc - m_t0[k]) < longint'((m_act[k] + 1) / 2);
`ifdef CLK_DIV_TICK_EN
          e.tick[k] = (cyc == m_t0[k]);
`endif
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic [N_CH-1:0] en_v, input logic load_v,
                               input logic sync_v, input logic [N_CH*RW-1:0] ratio_v);
    exp_t e;
    @(negedge ref_clk);
    rst    = rst_v;
    en     = en_v;
    load   = load_v;
    sync   = sync_v;
    ratios = ratio_v;
    modelStep(e);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, cur_en, 1'b0, 1'b0, cur_ratio);
  endtask

  task automatic loadRatios(input logic [N_CH*RW-1:0] r);
    cur_ratio = r;
    applyStimulus(1'b0, cur_en, 1'b1, 1'b0, cur_ratio);
  endtask

  task automatic checkOutput(input string name, input int ch, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s ch%0d cycle %0d: got %b expected %b", name, ch, mon_cyc, act, exp);
    end
  endtask

  // Monitor: one expected entry per reference edge, compared just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge ref_clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        mon_cyc++;
        for (int k = 0; k < N_CH; k++) begin
          checkOutput("div_clk", k, div_clk[k], e.div[k]);
          checkOutput("ratio_ack", k, ratio_ack[k], e.ack[k]);
          checkOutput("tick", k, tick[k], e.tick[k]);
        end
      end
    end
  end

  initial begin
    int waited;
    for (int k = 0; k < N_CH; k++) begin
      m_act[k]     = RST_RATIO;
      m_pendv[k]   = 0;
      m_pend[k]    = 1'b0;
      m_started[k] = 1'b0;
      m_t0[k]      = 0;
    end
    cur_en    = '1;
    cur_ratio = pack4(2, 2, 2, 2);
    rst    = 1'b1;
    en     = cur_en;
    load   = 1'b0;
    sync   = 1'b0;
    ratios = cur_ratio;

    $display("[TB] reset and default ratio");
    repeat (5) applyStimulus(1'b1, cur_en, 1'b0, 1'b0, cur_ratio);
    idle(8);

    $display("[TB] ratios 5 and 4");
    loadRatios(pack4(5, 4, 2, 2));
    idle(20);

    $display("[TB] bypass and back to 7");
    loadRatios(pack4(5, 4, 1, 2));
    idle(6);
    loadRatios(pack4(5, 4, 7, 2));
    idle(20);

    $display("[TB] channel 3 disabled with load");
    cur_en[3] = 1'b0;
    idle(2);
    loadRatios(pack4(5, 4, 7, 3));
    idle(3);
    cur_en[3] = 1'b1;
    idle(12);

    $display("[TB] sync with simultaneous load");
    loadRatios(pack4(5, 4, 6, 3));
    idle(9);
    cur_ratio = pack4(2, 3, 4, 5);
    applyStimulus(1'b0, cur_en, 1'b1, 1'b1, cur_ratio);
    idle(15);

    $display("[TB] ratio 6 everywhere");
    loadRatios(pack4(6, 6, 6, 6));
    idle(24);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      logic r_v;
      logic l_v;
      logic s_v;
      for (int k = 0; k < N_CH; k++)
        if ($urandom_range(0, 15) == 0) cur_en[k] = ~cur_en[k];
      l_v = ($urandom_range(0, 9) == 0);
      if (l_v)
        for (int k = 0; k < N_CH; k++) cur_ratio[k*RW +: RW] = RW'($urandom_range(0, 12));
      s_v = ($urandom_range(0, 19) == 0);
      r_v = ($urandom_range(0, 199) == 0);
      applyStimulus(r_v, cur_en, l_v, s_v, cur_ratio);
    end
    cur_en = '1;
    idle(3);

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge ref_clk);
      #2;
      waited++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d entries left expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
